// File: rtl/seg_display_capture.sv
// Seven-segment scan monitor: samples multiplexed C/DD/AN lines, decodes each digit back to
// a hex nibble and publishes one four-digit frame per complete scan, with a stale-scan flag.
module seg_display_capture #(
  parameter int SETTLE    = 4,
  parameter int TIMEOUT_W = 20
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic [7:0]  i_c,
  input  logic        i_dd,
  input  logic [3:0]  i_an,
  output logic [15:0] o_value,
  output logic [3:0]  o_dp,
  output logic [3:0]  o_blank,
  output logic [3:0]  o_seg_err,
  output logic        o_valid,
  output logic        o_stale
);

  localparam int CW = $clog2(SETTLE + 1);
  localparam logic [CW-1:0] SETTLE_C = CW'(SETTLE);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_HOLD   = 2'd2
  } state_t;

  // C[7] carries no information for the decoder.
  logic w_unused_c7;
  assign w_unused_c7 = i_c[7];

  logic [6:0]           r_c;
  logic                 r_dd;
  logic [3:0]           r_an;
  logic [3:0]           r_cur_an;
  state_t               r_state;
  state_t               w_state_next;
  logic [CW-1:0]        r_cnt;
  logic [CW-1:0]        w_cnt_next;
  logic                 w_load_cur;
  logic                 w_sample;
  logic [3:0]           r_seen;
  logic [3:0]           w_seen_merged;
  logic                 w_frame;
  logic [TIMEOUT_W-1:0] r_stale_cnt;
  logic                 w_stale_max;
  logic                 r_stale;
  logic                 r_valid;
  logic [15:0]          r_value;
  logic [3:0]           r_dp;
  logic [3:0]           r_blank;
  logic [3:0]           r_seg_err;

  logic [3:0] w_an_act;
  logic       w_one_hot;
  logic       w_an_changed;
  logic [3:0] w_nib;
  logic       w_blank;
  logic       w_err;

  logic [3:0] r_slot_val   [4];
  logic       r_slot_dp    [4];
  logic       r_slot_blank [4];
  logic       r_slot_err   [4];

  logic [15:0] w_frame_val;
  logic [3:0]  w_frame_dp;
  logic [3:0]  w_frame_blank;
  logic [3:0]  w_frame_err;

  // Input register: every decision below looks only at these copies.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_c  <= 7'h7F;
      r_dd <= 1'b1;
      r_an <= 4'hF;
    end else begin
      r_c  <= i_c[6:0];
      r_dd <= i_dd;
      r_an <= i_an;
    end
  end

  assign w_an_act     = ~r_an;
  assign w_one_hot    = (w_an_act != 4'd0) && ((w_an_act & (w_an_act - 4'd1)) == 4'd0);
  assign w_an_changed = (r_an != r_cur_an);

  always_comb begin
    w_nib   = 4'd0;
    w_blank = 1'b0;
    w_err   = 1'b0;
    case (r_c)
      7'h40: w_nib = 4'h0;
      7'h79: w_nib = 4'h1;
      7'h24: w_nib = 4'h2;
      7'h30: w_nib = 4'h3;
      7'h19: w_nib = 4'h4;
      7'h12: w_nib = 4'h5;
      7'h02: w_nib = 4'h6;
      7'h78: w_nib = 4'h7;
      7'h00: w_nib = 4'h8;
      7'h10: w_nib = 4'h9;
      7'h08: w_nib = 4'hA;
      7'h03: w_nib = 4'hB;
      7'h46: w_nib = 4'hC;
      7'h21: w_nib = 4'hD;
      7'h06: w_nib = 4'hE;
      7'h0E: w_nib = 4'hF;
      7'h7F: w_blank = 1'b1;
      default: w_err = 1'b1;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state  <= ST_IDLE;
      r_cnt    <= '0;
      r_cur_an <= 4'hF;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
      if (w_load_cur) begin
        r_cur_an <= r_an;
      end
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    w_load_cur   = 1'b0;
    w_sample     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_one_hot) begin
          w_state_next = ST_SETTLE;
          w_cnt_next   = CNT_ONE;
          w_load_cur   = 1'b1;
        end
      end
      ST_SETTLE: begin
        // An anode change always restarts or abandons the dwell, even on the sample cycle.
        if (w_an_changed) begin
          w_state_next = w_one_hot ? ST_SETTLE : ST_IDLE;
          w_cnt_next   = CNT_ONE;
          w_load_cur   = 1'b1;
        end else if (r_cnt == SETTLE_C) begin
          w_sample     = 1'b1;
          w_state_next = ST_HOLD;
        end else begin
          w_cnt_next = r_cnt + CNT_ONE;
        end
      end
      ST_HOLD: begin
        if (w_an_changed) begin
          w_state_next = w_one_hot ? ST_SETTLE : ST_IDLE;
          w_cnt_next   = CNT_ONE;
          w_load_cur   = 1'b1;
        end
      end
      default: begin
        w_state_next = ST_IDLE;
        w_cnt_next   = '0;
      end
    endcase
  end

  // Per-digit capture slots; the frame view merges the digit being sampled this cycle so
  // the frame can be published in the same cycle as the fourth sample.
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_slot
      always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
          r_slot_val[gi]   <= 4'd0;
          r_slot_dp[gi]    <= 1'b0;
          r_slot_blank[gi] <= 1'b0;
          r_slot_err[gi]   <= 1'b0;
        end else if (w_sample && w_an_act[gi]) begin
          r_slot_val[gi]   <= w_nib;
          r_slot_dp[gi]    <= ~r_dd;
          r_slot_blank[gi] <= w_blank;
          r_slot_err[gi]   <= w_err;
        end
      end

      assign w_frame_val[4*gi+3:4*gi] = w_an_act[gi] ? w_nib   : r_slot_val[gi];
      assign w_frame_dp[gi]           = w_an_act[gi] ? ~r_dd   : r_slot_dp[gi];
      assign w_frame_blank[gi]        = w_an_act[gi] ? w_blank : r_slot_blank[gi];
      assign w_frame_err[gi]          = w_an_act[gi] ? w_err   : r_slot_err[gi];
    end
  endgenerate

  assign w_seen_merged = r_seen | w_an_act;
  assign w_frame       = w_sample && (w_seen_merged == 4'b1111);
  assign w_stale_max   = &r_stale_cnt;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_seen      <= 4'd0;
      r_stale_cnt <= '0;
      r_stale     <= 1'b0;
    end else if (w_sample) begin
      r_seen      <= w_frame ? 4'd0 : w_seen_merged;
      r_stale_cnt <= '0;
      r_stale     <= 1'b0;
    end else if (w_stale_max) begin
      // A scan that stalls this long cannot be stitched to its earlier digits.
      r_seen  <= 4'd0;
      r_stale <= 1'b1;
    end else begin
      r_stale_cnt <= r_stale_cnt + 1'b1;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_valid   <= 1'b0;
      r_value   <= 16'd0;
      r_dp      <= 4'd0;
      r_blank   <= 4'd0;
      r_seg_err <= 4'd0;
    end else begin
      r_valid <= w_frame;
      if (w_frame) begin
        r_value   <= w_frame_val;
        r_dp      <= w_frame_dp;
        r_blank   <= w_frame_blank;
        r_seg_err <= w_frame_err;
      end
    end
  end

  assign o_value   = r_value;
  assign o_dp      = r_dp;
  assign o_blank   = r_blank;
  assign o_seg_err = r_seg_err;
  assign o_valid   = r_valid;
  assign o_stale   = r_stale;

endmodule

// File: tb/tb_seg_display_capture.sv
// Directed bench for seg_display_capture: table-driven full scans plus hand-written
// sequences for short dwell, overlapping anodes, stale timeout and mid-frame reset.
module tb_seg_display_capture;

  localparam int SETTLE    = 4;
  localparam int TIMEOUT_W = 6;
  localparam int DWELL     = 10;

  logic        clk;
  logic        rst_n;
  logic [7:0]  c;
  logic        dd;
  logic [3:0]  an;
  logic [15:0] o_value;
  logic [3:0]  o_dp;
  logic [3:0]  o_blank;
  logic [3:0]  o_seg_err;
  logic        o_valid;
  logic        o_stale;

  seg_display_capture #(.SETTLE(SETTLE), .TIMEOUT_W(TIMEOUT_W)) dut (
    .i_clk     (clk),
    .i_rst_n   (rst_n),
    .i_c       (c),
    .i_dd      (dd),
    .i_an      (an),
    .o_value   (o_value),
    .o_dp      (o_dp),
    .o_blank   (o_blank),
    .o_seg_err (o_seg_err),
    .o_valid   (o_valid),
    .o_stale   (o_stale)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int valid_cnt = 0;
  int valid_cyc = 0;
  logic prev_valid = 1'b0;
  logic [15:0] cap_value;
  logic [3:0]  cap_dp, cap_blank, cap_err;
  logic        c7 = 1'b1;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (o_valid) begin
      valid_cnt = valid_cnt + 1;
      valid_cyc = cyc;
      cap_value = o_value;
      cap_dp    = o_dp;
      cap_blank = o_blank;
      cap_err   = o_seg_err;
      checks = checks + 1;
      if (prev_valid) begin
        errors = errors + 1;
        $display("FAIL valid_back_to_back: valid high on consecutive cycles at cycle %0d", cyc);
      end
    end
    prev_valid = o_valid;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks = checks + 1;
    if (act !== exp) begin
      errors = errors + 1;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end else begin
      $display("ok   %s: %h", nm, act);
    end
  endtask

  // Drives one digit for n cycles; returns the cycle on which the anode was driven.
  task automatic show(input int idx, input logic [6:0] code, input logic dd_n, input int n,
                      output int drive_cyc);
    an = ~(4'b0001 << idx);
    c  = {c7, code};
    dd = dd_n;
    drive_cyc = cyc;
    repeat (n) tick();
  endtask

  typedef struct {
    logic [27:0] codes;
    logic [3:0]  dd_n;
    logic [15:0] exp_val;
    logic [3:0]  exp_dp;
    logic [3:0]  exp_blank;
    logic [3:0]  exp_err;
  } vec_t;

  vec_t vecs[6];

  initial begin
    int base;
    int dc;
    int an0_cyc;

    vecs[0] = '{codes: {7'h79, 7'h24, 7'h30, 7'h19}, dd_n: 4'b1111, exp_val: 16'h1234,
                exp_dp: 4'b0000, exp_blank: 4'b0000, exp_err: 4'b0000};
    vecs[1] = '{codes: {7'h08, 7'h03, 7'h46, 7'h21}, dd_n: 4'b0111, exp_val: 16'hABCD,
                exp_dp: 4'b1000, exp_blank: 4'b0000, exp_err: 4'b0000};
    vecs[2] = '{codes: {7'h06, 7'h0E, 7'h40, 7'h10}, dd_n: 4'b1111, exp_val: 16'hEF09,
                exp_dp: 4'b0000, exp_blank: 4'b0000, exp_err: 4'b0000};
    vecs[3] = '{codes: {7'h00, 7'h55, 7'h00, 7'h7F}, dd_n: 4'b0101, exp_val: 16'h8080,
                exp_dp: 4'b1010, exp_blank: 4'b0001, exp_err: 4'b0100};
    vecs[4] = '{codes: {7'h12, 7'h02, 7'h78, 7'h00}, dd_n: 4'b1111, exp_val: 16'h5678,
                exp_dp: 4'b0000, exp_blank: 4'b0000, exp_err: 4'b0000};
    vecs[5] = '{codes: {7'h7D, 7'h40, 7'h7F, 7'h01}, dd_n: 4'b1110, exp_val: 16'h0000,
                exp_dp: 4'b0001, exp_blank: 4'b0010, exp_err: 4'b1001};

    rst_n = 1'b0;
    an = 4'hF;
    c  = 8'hFF;
    dd = 1'b1;
    repeat (3) tick();
    chk("reset_value", 32'(o_value), 32'h0);
    chk("reset_dp", 32'(o_dp), 32'h0);
    chk("reset_blank", 32'(o_blank), 32'h0);
    chk("reset_segerr", 32'(o_seg_err), 32'h0);
    chk("reset_valid", 32'(o_valid), 32'h0);
    chk("reset_stale", 32'(o_stale), 32'h0);
    rst_n = 1'b1;
    tick();

    // Table-driven full scans, digit 3 first.
    for (int v = 0; v < 6; v++) begin
      base = valid_cnt;
      c7 = v[0];
      an0_cyc = 0;
      for (int d = 3; d >= 0; d--) begin
        show(d, vecs[v].codes[7*d +: 7], vecs[v].dd_n[d], DWELL, dc);
        if (d == 0) an0_cyc = dc;
      end
      $display("vec %0d: codes=%h dd_n=%b", v, vecs[v].codes, vecs[v].dd_n);
      chk($sformatf("vec%0d_valid_count", v), 32'(valid_cnt - base), 32'd1);
      chk($sformatf("vec%0d_value", v), 32'(cap_value), 32'(vecs[v].exp_val));
      chk($sformatf("vec%0d_dp", v), 32'(cap_dp), 32'(vecs[v].exp_dp));
      chk($sformatf("vec%0d_blank", v), 32'(cap_blank), 32'(vecs[v].exp_blank));
      chk($sformatf("vec%0d_segerr", v), 32'(cap_err), 32'(vecs[v].exp_err));
      if (v == 0) chk("valid_latency", 32'(valid_cyc - an0_cyc), 32'(SETTLE + 2));
    end
    c7 = 1'b1;

    // Short dwell on AN1 is ignored; the frame completes only on a full AN1 dwell.
    base = valid_cnt;
    show(3, 7'h10, 1'b1, DWELL, dc);
    show(2, 7'h00, 1'b1, DWELL, dc);
    show(1, 7'h79, 1'b1, SETTLE - 1, dc);
    show(0, 7'h02, 1'b1, DWELL, dc);
    chk("short_dwell_no_valid", 32'(valid_cnt - base), 32'd0);
    show(1, 7'h78, 1'b1, DWELL, dc);
    chk("short_dwell_valid_count", 32'(valid_cnt - base), 32'd1);
    chk("short_dwell_value", 32'(cap_value), 32'h9876);

    // Two anodes lit at once: nothing is sampled, then a normal scan succeeds.
    base = valid_cnt;
    an = 4'b1100;
    c  = {1'b1, 7'h79};
    dd = 1'b0;
    repeat (50) tick();
    chk("overlap_no_valid", 32'(valid_cnt - base), 32'd0);
    show(3, 7'h24, 1'b1, DWELL, dc);
    show(2, 7'h19, 1'b1, DWELL, dc);
    show(1, 7'h02, 1'b1, DWELL, dc);
    show(0, 7'h00, 1'b1, DWELL, dc);
    chk("overlap_valid_count", 32'(valid_cnt - base), 32'd1);
    chk("overlap_value", 32'(cap_value), 32'h2468);
    chk("overlap_dp", 32'(cap_dp), 32'h0);

    // Stale: partial frame, long idle, stale clears the partial digits.
    base = valid_cnt;
    show(3, 7'h46, 1'b1, DWELL, dc);
    show(2, 7'h06, 1'b1, DWELL, dc);
    an = 4'hF;
    repeat (30) tick();
    chk("stale_not_yet", 32'(o_stale), 32'd0);
    repeat (50) tick();
    chk("stale_set", 32'(o_stale), 32'd1);
    chk("stale_keeps_value", 32'(o_value), 32'h2468);
    show(1, 7'h40, 1'b1, DWELL, dc);
    chk("stale_cleared", 32'(o_stale), 32'd0);
    show(0, 7'h19, 1'b1, DWELL, dc);
    chk("stale_partial_dropped", 32'(valid_cnt - base), 32'd0);
    show(3, 7'h46, 1'b1, DWELL, dc);
    show(2, 7'h06, 1'b1, DWELL, dc);
    chk("stale_resume_count", 32'(valid_cnt - base), 32'd1);
    chk("stale_resume_value", 32'(cap_value), 32'hCE04);

    // Reset mid-frame, then scan in an order that would expose leftover slots.
    show(3, 7'h78, 1'b1, DWELL, dc);
    show(2, 7'h10, 1'b1, DWELL, dc);
    rst_n = 1'b0;
    repeat (2) tick();
    chk("midreset_value", 32'(o_value), 32'h0);
    chk("midreset_valid", 32'(o_valid), 32'h0);
    rst_n = 1'b1;
    tick();
    base = valid_cnt;
    show(1, 7'h08, 1'b1, DWELL, dc);
    show(0, 7'h03, 1'b1, DWELL, dc);
    show(3, 7'h21, 1'b1, DWELL, dc);
    show(2, 7'h0E, 1'b1, DWELL, dc);
    chk("postreset_valid_count", 32'(valid_cnt - base), 32'd1);
    chk("postreset_value", 32'(cap_value), 32'hDFAB);

    an = 4'hF;
    repeat (3) tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
